// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped cache controller.
// state_t   : controller FSM states
// WORD_W    : core data word width
// LINE_W    : cache line width (four words)
// ADDR_W    : core word-address width
// MEM_ADDR_W: line-address width toward slow_memory
// idx_w/tag_w: index and tag widths for a given number of lines
package cache_pkg;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = 128;
  localparam int unsigned ADDR_W     = 30;
  localparam int unsigned MEM_ADDR_W = 28;

  // NUM_BLOCKS is a power of two, at least 2.
  function automatic int unsigned idx_w(input int unsigned num_blocks);
    return $clog2(num_blocks);
  endfunction

  function automatic int unsigned tag_w(input int unsigned num_blocks);
    return MEM_ADDR_W - idx_w(num_blocks);
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// Bus bundle between the core data port, the cache controller and slow_memory.
// proc_*    : core request (read/write/addr/wdata) and response (stall/rdata)
// mem_*     : line request (read/write/addr/wdata) and response (rdata/ready)
// Modports  : master = cache controller, slave = core + memory environment.
interface dm_cache_ctrl_if;

  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;

  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport master (
    input  proc_read, proc_write, proc_addr, proc_wdata,
    output proc_stall, proc_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output proc_read, proc_write, proc_addr, proc_wdata,
    input  proc_stall, proc_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/cache_line_store.sv
// Storage for the direct-mapped cache: valid, dirty, tag and line data.
// clk, rst_n   : clock; async active-low reset clears valid/dirty only
// idx_i        : line index for read, word write and fill
// valid_o, dirty_o, tag_o, line_o : asynchronous read of the indexed line
// wr_en_i, wr_word_i, wr_data_i   : word write on a hit (also sets dirty)
// fill_en_i, fill_tag_i, fill_line_i : whole-line fill (valid=1, dirty=0)
module cache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 8,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned TAG_W      = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_W-1:0]     idx_i,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic [LINE_W-1:0]    line_o,
  input  logic                 wr_en_i,
  input  logic [1:0]           wr_word_i,
  input  logic [WORD_W-1:0]    wr_data_i,
  input  logic                 fill_en_i,
  input  logic [TAG_W-1:0]     fill_tag_i,
  input  logic [LINE_W-1:0]    fill_line_i
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data carry no reset; they are qualified by valid.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (wr_en_i) begin
      data_q[idx_i][{wr_word_i, 5'b0} +: WORD_W] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller between the
// core data port and slow_memory.
// clk   : clock, all state on posedge
// rst_n : async active-low reset
// bus   : dm_cache_ctrl_if.master carrying the proc_* request/response and
//         the registered mem_* line request toward slow_memory.
// A miss stalls the core; a dirty victim is written back before the fetch.
module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 8,
  parameter int unsigned LINE_W     = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  dm_cache_ctrl_if.master   bus
);

  localparam int unsigned IDX_W = idx_w(NUM_BLOCKS);
  localparam int unsigned TAG_W = tag_w(NUM_BLOCKS);

  state_t state_q, state_d;

  logic                  mem_read_q,  mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [LINE_W-1:0]     mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]  proc_idx;
  logic [TAG_W-1:0]  proc_tag;
  logic [1:0]        proc_word;
  logic              req;
  logic              is_read;

  logic              line_valid;
  logic              line_dirty;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;
  logic              hit;

  logic              wr_en;
  logic              fill_en;
  logic              stall;
  logic [WORD_W-1:0] rdata;

  assign proc_word = bus.proc_addr[1:0];
  assign proc_idx  = bus.proc_addr[IDX_W+1:2];
  assign proc_tag  = bus.proc_addr[ADDR_W-1:IDX_W+2];
  assign req       = bus.proc_read | bus.proc_write;
  // Read wins when both strobes are high.
  assign is_read   = bus.proc_read;
  assign hit       = line_valid && (line_tag == proc_tag);

  cache_line_store #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx_i       (proc_idx),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .line_o      (line_data),
    .wr_en_i     (wr_en),
    .wr_word_i   (proc_word),
    .wr_data_i   (bus.proc_wdata),
    .fill_en_i   (fill_en),
    .fill_tag_i  (proc_tag),
    .fill_line_i (bus.mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COMPARE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall       = 1'b0;
    rdata       = '0;
    wr_en       = 1'b0;
    fill_en     = 1'b0;

    unique case (state_q)
      COMPARE: begin
        if (req) begin
          if (hit) begin
            if (is_read) begin
              rdata = line_data[{proc_word, 5'b0} +: WORD_W];
            end else begin
              wr_en = 1'b1;
            end
          end else begin
            stall = 1'b1;
            if (line_valid && line_dirty) begin
              state_d     = WRITEBACK;
              mem_write_d = 1'b1;
              mem_addr_d  = {line_tag, proc_idx};
              mem_wdata_d = line_data;
            end else begin
              state_d    = ALLOCATE;
              mem_read_d = 1'b1;
              mem_addr_d = bus.proc_addr[ADDR_W-1:2];
            end
          end
        end
      end

      WRITEBACK: begin
        stall = 1'b1;
        if (bus.mem_ready) begin
          state_d     = ALLOCATE;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = bus.proc_addr[ADDR_W-1:2];
        end
      end

      ALLOCATE: begin
        stall = 1'b1;
        if (bus.mem_ready) begin
          state_d    = COMPARE;
          mem_read_d = 1'b0;
          fill_en    = 1'b1;
        end
      end

      default: begin
        state_d = COMPARE;
      end
    endcase
  end

  assign bus.proc_stall = stall;
  assign bus.proc_rdata = rdata;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: cold miss, hit, write hit, dirty and
// clean eviction, simultaneous read/write, reset during a line fetch.
module tb_dm_cache_ctrl;

  logic clk;
  logic rst_n;
  int unsigned total;
  int unsigned bad;

  dm_cache_ctrl_if bus ();

  dm_cache_ctrl #(
    .NUM_BLOCKS (8),
    .LINE_W     (128)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] LINE_A = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
  localparam logic [127:0] LINE_B = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
  localparam logic [127:0] LINE_C = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hDEADBEEF, 32'hA0A0A0A0};
  localparam logic [127:0] LINE_D = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};

  logic [127:0] wd;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_rdata  = '0;
    bus.mem_ready  = 1'b0;

    step();
    step();
    chk("rst_mem_read",  bus.mem_read,  1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_addr",  bus.mem_addr,  28'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 128'h0);
    chk("rst_stall",     bus.proc_stall, 1'b0);
    chk("rst_rdata",     bus.proc_rdata, 32'h0);
    rst_n = 1'b1;
    step();

    // Cold read miss at 0x5.
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h5;
    #1;
    chk("cold_stall", bus.proc_stall, 1'b1);
    step();
    chk("cold_mem_read",  bus.mem_read,  1'b1);
    chk("cold_mem_addr",  bus.mem_addr,  28'h1);
    chk("cold_mem_write", bus.mem_write, 1'b0);
    step();
    chk("cold_wait_read",  bus.mem_read,  1'b1);
    chk("cold_wait_stall", bus.proc_stall, 1'b1);
    bus.mem_rdata = LINE_A;
    bus.mem_ready = 1'b1;
    #1;
    chk("cold_ready_stall", bus.proc_stall, 1'b1);
    step();
    bus.mem_ready = 1'b0;
    #1;
    chk("cold_done_stall", bus.proc_stall, 1'b0);
    chk("cold_done_rdata", bus.proc_rdata, 32'hA1A1A1A1);
    chk("cold_done_mread", bus.mem_read, 1'b0);
    chk("cold_done_mwrite", bus.mem_write, 1'b0);
    bus.proc_read = 1'b0;
    step();

    // Read hit at 0x5, and word 3 of the same line.
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h5;
    #1;
    chk("hit_stall", bus.proc_stall, 1'b0);
    chk("hit_rdata", bus.proc_rdata, 32'hA1A1A1A1);
    step();
    chk("hit_mem_read",  bus.mem_read,  1'b0);
    chk("hit_mem_write", bus.mem_write, 1'b0);
    bus.proc_addr = 30'h7;
    #1;
    chk("hit_w3_rdata", bus.proc_rdata, 32'hA3A3A3A3);
    bus.proc_read = 1'b0;
    #1;
    chk("idle_rdata", bus.proc_rdata, 32'h0);
    step();

    // Write hit, then read back.
    bus.proc_write = 1'b1;
    bus.proc_addr  = 30'h5;
    bus.proc_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_stall", bus.proc_stall, 1'b0);
    step();
    bus.proc_write = 1'b0;
    bus.proc_read  = 1'b1;
    #1;
    chk("wr_readback", bus.proc_rdata, 32'hDEADBEEF);
    step();

    // Dirty eviction: 0x25 shares index 1 with tag 1.
    bus.proc_addr = 30'h25;
    #1;
    chk("dirty_stall", bus.proc_stall, 1'b1);
    step();
    wd = bus.mem_wdata;
    chk("wb_mem_write", bus.mem_write, 1'b1);
    chk("wb_mem_read",  bus.mem_read,  1'b0);
    chk("wb_mem_addr",  bus.mem_addr,  28'h1);
    chk("wb_word1",     wd[63:32],     32'hDEADBEEF);
    chk("wb_line",      bus.mem_wdata, LINE_C);
    step();
    chk("wb_hold_write", bus.mem_write, 1'b1);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    #1;
    chk("alloc_mem_write", bus.mem_write, 1'b0);
    chk("alloc_mem_read",  bus.mem_read,  1'b1);
    chk("alloc_mem_addr",  bus.mem_addr,  28'h9);
    chk("alloc_stall",     bus.proc_stall, 1'b1);
    bus.mem_rdata = LINE_B;
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    #1;
    chk("evict_done_stall", bus.proc_stall, 1'b0);
    chk("evict_done_rdata", bus.proc_rdata, 32'hB1B1B1B1);
    bus.proc_read = 1'b0;
    step();

    // Simultaneous read and write on a hit: read served, write dropped.
    bus.proc_read  = 1'b1;
    bus.proc_write = 1'b1;
    bus.proc_addr  = 30'h25;
    bus.proc_wdata = 32'h12345678;
    #1;
    chk("rw_stall", bus.proc_stall, 1'b0);
    chk("rw_rdata", bus.proc_rdata, 32'hB1B1B1B1);
    step();
    bus.proc_write = 1'b0;
    #1;
    chk("rw_unchanged", bus.proc_rdata, 32'hB1B1B1B1);
    bus.proc_read = 1'b0;
    step();

    // Clean eviction: back to 0x5, victim line (tag 1) is clean.
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h5;
    step();
    chk("clean_mem_write", bus.mem_write, 1'b0);
    chk("clean_mem_read",  bus.mem_read,  1'b1);
    chk("clean_mem_addr",  bus.mem_addr,  28'h1);
    bus.mem_rdata = LINE_C;
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    #1;
    chk("clean_done_rdata", bus.proc_rdata, 32'hDEADBEEF);
    chk("clean_done_stall", bus.proc_stall, 1'b0);
    bus.proc_read = 1'b0;
    step();

    // Reset during ALLOCATE on 0x9 (index 2).
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h9;
    step();
    chk("ra_mem_read", bus.mem_read, 1'b1);
    chk("ra_mem_addr", bus.mem_addr, 28'h2);
    rst_n = 1'b0;
    #1;
    chk("ra_rst_read", bus.mem_read, 1'b0);
    chk("ra_rst_addr", bus.mem_addr, 28'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("ra_after_stall", bus.proc_stall, 1'b1);
    step();
    chk("ra_refetch_read", bus.mem_read, 1'b1);
    chk("ra_refetch_addr", bus.mem_addr, 28'h2);
    bus.mem_rdata = LINE_D;
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    #1;
    chk("ra_done_rdata", bus.proc_rdata, 32'hD1D1D1D1);
    bus.proc_read = 1'b0;
    step();

    // Line at 0x5 was valid before the reset; it must miss now.
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h5;
    #1;
    chk("ra_inval_stall", bus.proc_stall, 1'b1);
    step();
    chk("ra_inval_write", bus.mem_write, 1'b0);
    chk("ra_inval_read",  bus.mem_read,  1'b1);
    bus.mem_rdata = LINE_C;
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    bus.proc_read = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Direct-mapped, write-back, write-allocate cache controller between the RISC-V core's data port and `slow_memory`. It serves word reads and writes from the core, stalling the core on a miss. On a miss it writes back a dirty victim line and fetches the missing 128-bit line over the memory's hold-until-ready handshake. It is the block directly upstream of `slow_memory` and drives its request inputs.

## Interface
- `NUM_BLOCKS`, default 8: number of cache lines, a power of two. Index width is `IDX_W = log2(NUM_BLOCKS)`, default 3.
- `LINE_W`, default 128: line width, fixed at 4 × 32-bit words.
- `clk` in 1: clock. All state updates on the posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `proc_read` in 1: core read request, held until `proc_stall`=0.
- `proc_write` in 1: core write request, held until `proc_stall`=0.
- `proc_addr` in 30: word address. Bits [1:0] are the word offset, [IDX_W+1:2] the index, and the remaining bits the tag (25 b by default).
- `proc_wdata` in 32: write data.
- `proc_stall` out 1: combinational. High while a request is not completed this cycle.
- `proc_rdata` out 32: combinational read data. Valid when `proc_read`=1 and `proc_stall`=0.
- `mem_read` out 1: registered line-fetch request.
- `mem_write` out 1: registered line-writeback request.
- `mem_addr` out 28: registered line address, {tag, index}.
- `mem_wdata` out 128: registered victim line, with word 0 in [31:0].
- `mem_rdata` in 128: fetched line, with word 0 in [31:0].
- `mem_ready` in 1: one-cycle pulse ending a memory transaction.

## Operation
- Per line: `valid`, `dirty`, `tag`, and 128 data bits. Reset clears all `valid` and `dirty` bits. Data and tag contents are don't-care after reset.
- States:
  - `COMPARE` (reset state).
  - `WRITEBACK`.
  - `ALLOCATE`.
- A request is active when `proc_read` or `proc_write` is high. If both are high, it is treated as a read and the write is ignored.
- `COMPARE`, no request: stay. `proc_stall`=0.
- `COMPARE`, hit (`valid` and tag match):
  - `proc_stall`=0.
  - Read: `proc_rdata` = the addressed word.
  - Write: at the posedge, the addressed word ← `proc_wdata` and `dirty`←1.
  - Stay in `COMPARE`.
- `COMPARE`, miss: `proc_stall`=1.
  - Victim valid and dirty: → `WRITEBACK`. Register `mem_write`=1, `mem_addr`={victim tag, index}, `mem_wdata`=victim line.
  - Otherwise: → `ALLOCATE`. Register `mem_read`=1, `mem_addr`=`proc_addr[29:2]`.
- `WRITEBACK`: hold all memory outputs stable. On `mem_ready`=1:
  - `mem_write`←0.
  - `mem_read`←1, `mem_addr`←`proc_addr[29:2]`.
  - → `ALLOCATE`.
- `ALLOCATE`: hold all memory outputs stable. On `mem_ready`=1:
  - The line ← `mem_rdata`, `tag` ← request tag, `valid`←1, `dirty`←0.
  - `mem_read`←0.
  - → `COMPARE`. The retried request then hits.
- `proc_stall`=1 in `WRITEBACK` and `ALLOCATE` regardless of `mem_ready`.
- `mem_read` and `mem_write` are never high together.
- `mem_ready` is ignored in `COMPARE`.
- Core request and address are held stable while stalled. Behaviour when they change mid-miss is undefined.

## Timing
- Reset values: `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, state=`COMPARE`. `proc_stall`=0 and `proc_rdata`=0 while no request is active.
- Hit latency is 0 stall cycles.
- Miss cost for a clean victim: allocate cycles up to and including `mem_ready`, plus 1 `COMPARE` cycle.
- Miss cost for a dirty victim adds the full writeback transaction before the allocate.
- Memory requests are deasserted in the cycle after the `mem_ready` posedge. `slow_memory` samples on the negedge, so the deassertion is seen before its IDLE state re-samples.
- Reset asserted mid-transaction:
  - Immediately returns to `COMPARE` and drops `mem_read`/`mem_write`.
  - Invalidates all lines.
  - The in-flight memory line content is not guaranteed.

## Structure
- Package `cache_pkg`:
  - `state_t` enum (`COMPARE`, `WRITEBACK`, `ALLOCATE`).
  - `WORD_W`=32, `LINE_W`=128, `ADDR_W`=30, `MEM_ADDR_W`=28.
  - Tag and index width functions.
- Sub-module `cache_line_store`:
  - Holds valid, dirty, tag and data arrays.
  - Asynchronous read, synchronous word write and line fill, async-reset valid/dirty.
- The controller FSM lives in `dm_cache_ctrl`.

## Test plan
- **Cold read miss:** reset, then read `proc_addr`=0x0000_0005. Required:
  - `mem_read`=1 with `mem_addr`=0x000_0001.
  - After `mem_ready`, `mem_rdata` word 1 appears on `proc_rdata` with stall released one cycle later.
  - `mem_write` stays 0.
- **Read hit:** repeat the read of 0x0000_0005. Required: `proc_stall`=0 in the same cycle, and no memory request.
- **Write hit then dirty eviction:**
  - Write 0xDEADBEEF to 0x0000_0005.
  - Then read 0x0000_0025, which maps to the same index with a different tag.
  - Required: `mem_write`=1 first, with `mem_addr`=0x000_0001 and `mem_wdata[63:32]`=0xDEADBEEF.
  - Then `mem_read`=1 with `mem_addr`=0x000_0009.
- **Clean eviction:** read 0x0000_0005 again after the previous scenario. Required: fetch only, with no writeback because the victim is clean.
- **Simultaneous read and write on a hit:** both asserted on address 0x0000_0025. Required: read data is returned and the line is unchanged.
- **Reset during `ALLOCATE`:** assert `rst_n`=0 while waiting on memory. Required:
  - `mem_read`=0 immediately.
  - The next access to the same address misses again.
